payload_streamer: RTL and testbench
===================================

Name: payload_streamer

Overview:
Parametrised testbench-side stimulus engine. The host (DPI task side) preloads a batch of multi-channel items into an internal buffer, then starts a stream. The block plays the batch out to the DUT bus with a valid/ready handshake, optionally repeating it, and signals completion. It replaces fixed-size, fixed-rate, two-operand payload playback with a configurable channel count, depth, length and repeat count, plus back-pressure support.

Parameters:
CHANNELS, 2, number of parallel item lanes per beat (channel 0 = operand A, channel 1 = operand B)
ITEM_WIDTH, 8, bits per item
DEPTH, 1000, buffer depth in beats
RPT_W, 8, width of repeat-count input
ADDR_W, $clog2(DEPTH), derived buffer address width (not overridden)
LEN_W, $clog2(DEPTH+1), derived length width (not overridden)

Ports:
clk_i  in  1  single clock, all logic on rising edge
reset_ni  in  1  synchronous active-low reset
wr_en_i  in  1  host buffer write strobe
wr_addr_i  in  ADDR_W  beat index to write
wr_data_i  in  CHANNELS*ITEM_WIDTH  beat data; channel k at [k*ITEM_WIDTH +: ITEM_WIDTH]
start_i  in  1  start-stream pulse
len_i  in  LEN_W  beats per pass, sampled with start_i
rpt_i  in  RPT_W  number of passes, sampled with start_i
abort_i  in  1  terminate stream
out_valid_o  out  1  beat valid to DUT
out_ready_i  in  1  DUT accepts beat
out_data_o  out  CHANNELS*ITEM_WIDTH  beat data, same packing as wr_data_i
out_last_o  out  1  current beat is last of a pass
busy_o  out  1  stream in progress
done_o  out  1  one-cycle pulse, stream completed normally
err_o  out  1  one-cycle pulse, illegal request rejected

Behaviour:
- Reset (reset_ni=0 at rising edge): FSM→IDLE; out_valid_o, out_last_o, busy_o, done_o, err_o = 0; out_data_o = 0; counters = 0. Buffer contents are not reset and are undefined after power-up.
- Reset asserted mid-stream: stream is dropped immediately; no done_o.
- Handshake: a beat transfers on a cycle with out_valid_o & out_ready_i.
  - While out_valid_o=1 and out_ready_i=0, out_data_o and out_last_o hold stable.
  - out_valid_o never drops without a transfer, except on abort or reset.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - Writes accepted: buf[wr_addr_i] ← wr_data_i. wr_addr_i ≥ DEPTH → write dropped, err_o pulse.
  - start_i with 1 ≤ len_i ≤ DEPTH: latch len and passes (passes = max(rpt_i,1)); go to STREAM. busy_o=1 from the next cycle.
  - start_i with len_i = 0 or len_i > DEPTH: ignored, err_o pulse, stay in IDLE.
  - Simultaneous write and valid start: write is committed, and the stream observes the new data (write-first).
- STREAM:
  - First beat (buf[0]) is presented with out_valid_o=1 exactly 1 cycle after the start cycle.
  - After each transfer, the next beat is presented in the following cycle; zero bubbles when out_ready_i is held high (1 beat/cycle).
  - Beat index wraps from len-1 to 0 and the pass count increments. out_last_o=1 on index len-1.
  - Transfer of beat len-1 on the final pass → DONE.
  - wr_en_i while busy: ignored, err_o pulse. start_i while busy: ignored, err_o pulse.
- DONE (1 cycle): done_o=1, busy_o=0, out_valid_o=0; then → IDLE.
- abort_i in STREAM (takes priority over a transfer in the same cycle, which is treated as not accepted): next cycle → IDLE, out_valid_o=0, busy_o=0, no done_o. abort_i in IDLE or DONE has no effect.
- Latency: start → first valid = 1 cycle. Final transfer → done_o = 1 cycle.
- Total transfers of a completed stream = len × passes.

Test Plan:
- Load beats 0..3 with {B=i+10, A=i} (CHANNELS=2), start len=4 rpt=1, ready held 1 → out_data A/B = 0/10, 1/11, 2/12, 3/13 on 4 consecutive cycles; out_last only on the 4th; done_o pulses 1 cycle after; busy_o covers exactly cycles 1–4 after start.
- Same load, len=4 rpt=3, ready toggling 1,0,1,0… → 12 transfers in order 0..3 ×3; data stable during every stall; out_last on transfers 4, 8 and 12; single done_o.
- start with len=0, then len=DEPTH+1 → err_o pulse each time; busy_o stays 0; no out_valid_o.
- During a stream: wr_en_i and start_i each asserted → err_o pulses; stream data unchanged; transfer count still len×passes.
- abort_i after 2 of 4 transfers → out_valid_o=0 next cycle; no done_o; a fresh start replays from beat 0.
- reset_ni=0 mid-stream for 1 cycle → all outputs 0 next cycle; a restart with len=DEPTH=1000 and ready=1 streams 1000 beats in 1000 cycles with index wrap correct.

Source files
------------

// File: rtl/payload_streamer.sv
// payload_streamer: host-loaded beat buffer played out over a valid/ready bus.
// The host fills the buffer while idle, then a start request streams beats
// 0..len-1 for the requested number of passes, with back-pressure support.
module payload_streamer #(
    parameter int CHANNELS   = 2,
    parameter int ITEM_WIDTH = 8,
    parameter int DEPTH      = 1000,
    parameter int RPT_W      = 8,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int LEN_W     = $clog2(DEPTH + 1),
    localparam int DATA_W    = CHANNELS * ITEM_WIDTH
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [RPT_W-1:0]  rpt_i,
    input  logic              abort_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [LEN_W-1:0]  len_r;
    logic [RPT_W-1:0]  passes_r;
    logic [RPT_W-1:0]  pass_r;
    logic [ADDR_W-1:0] idx_r;

    logic              wr_bad_s;
    logic              len_ok_s;
    logic              xfer_s;
    logic              last_idx_s;
    logic              last_pass_s;
    logic              mem_we_s;
    logic              bypass_s;
    logic [RPT_W-1:0]  passes_s;
    logic [ADDR_W-1:0] nxt_idx_s;
    logic [DATA_W-1:0] first_beat_s;
    logic [DATA_W-1:0] nxt_beat_s;

    // Request legality, handshake decode and next-beat selection
    always_comb begin
        wr_bad_s    = (LEN_W'(wr_addr_i) >= LEN_W'(DEPTH));
        len_ok_s    = (len_i != {LEN_W{1'b0}}) && (len_i <= LEN_W'(DEPTH));
        xfer_s      = out_valid_o & out_ready_i;
        last_idx_s  = (LEN_W'(idx_r) == (len_r - LEN_W'(1)));
        last_pass_s = (pass_r == (passes_r - RPT_W'(1)));
        nxt_idx_s   = idx_r + ADDR_W'(1);
        // Buffer is writable whenever no stream is being played
        mem_we_s    = reset_ni && wr_en_i && !wr_bad_s && (state_r != ST_STREAM);
        // A write to beat 0 in the start cycle must be seen by the first beat
        bypass_s    = mem_we_s && (wr_addr_i == {ADDR_W{1'b0}});
        if (rpt_i == {RPT_W{1'b0}}) begin
            passes_s = RPT_W'(1);
        end else begin
            passes_s = rpt_i;
        end
        if (bypass_s) begin
            first_beat_s = wr_data_i;
        end else begin
            first_beat_s = mem_r[0];
        end
        nxt_beat_s = mem_r[nxt_idx_s];
    end

    // Host buffer write port; contents are deliberately not reset
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_r[wr_addr_i] <= wr_data_i;
        end
    end

    // Stream control FSM with registered bus and status outputs
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_r     <= ST_IDLE;
            len_r       <= {LEN_W{1'b0}};
            passes_r    <= {RPT_W{1'b0}};
            pass_r      <= {RPT_W{1'b0}};
            idx_r       <= {ADDR_W{1'b0}};
            out_valid_o <= 1'b0;
            out_data_o  <= {DATA_W{1'b0}};
            out_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    err_o <= (wr_en_i && wr_bad_s) || (start_i && !len_ok_s);
                    if (start_i && len_ok_s) begin
                        state_r     <= ST_STREAM;
                        len_r       <= len_i;
                        passes_r    <= passes_s;
                        pass_r      <= {RPT_W{1'b0}};
                        idx_r       <= {ADDR_W{1'b0}};
                        out_valid_o <= 1'b1;
                        out_data_o  <= first_beat_s;
                        out_last_o  <= (len_i == LEN_W'(1));
                        busy_o      <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    err_o <= wr_en_i || start_i;
                    if (abort_i) begin
                        // Abort wins over a same-cycle handshake
                        state_r     <= ST_IDLE;
                        out_valid_o <= 1'b0;
                        out_last_o  <= 1'b0;
                        busy_o      <= 1'b0;
                    end else if (xfer_s) begin
                        if (last_idx_s) begin
                            if (last_pass_s) begin
                                state_r     <= ST_DONE;
                                out_valid_o <= 1'b0;
                                out_last_o  <= 1'b0;
                                busy_o      <= 1'b0;
                                done_o      <= 1'b1;
                            end else begin
                                idx_r      <= {ADDR_W{1'b0}};
                                pass_r     <= pass_r + RPT_W'(1);
                                out_data_o <= mem_r[0];
                                out_last_o <= (len_r == LEN_W'(1));
                            end
                        end else begin
                            idx_r      <= nxt_idx_s;
                            out_data_o <= nxt_beat_s;
                            out_last_o <= (LEN_W'(nxt_idx_s) == (len_r - LEN_W'(1)));
                        end
                    end else begin
                        // Stalled: beat and last flag hold
                        state_r <= ST_STREAM;
                    end
                end
                ST_DONE: begin
                    err_o   <= (wr_en_i && wr_bad_s) || start_i;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_o <= 1'b0;
                    out_last_o  <= 1'b0;
                    busy_o      <= 1'b0;
                    err_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payload_streamer.sv
// Bench for payload_streamer: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized streams.
module tb_payload_streamer;

    localparam int CH     = 2;
    localparam int IW     = 8;
    localparam int DEPTH  = 1000;
    localparam int RPT_W  = 8;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LEN_W  = $clog2(DEPTH + 1);
    localparam int DW     = CH * IW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_ni;
    logic              wr_en_i;
    logic [ADDR_W-1:0] wr_addr_i;
    logic [DW-1:0]     wr_data_i;
    logic              start_i;
    logic [LEN_W-1:0]  len_i;
    logic [RPT_W-1:0]  rpt_i;
    logic              abort_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [DW-1:0]     out_data_o;
    logic              out_last_o;
    logic              busy_o;
    logic              done_o;
    logic              err_o;

    always #5 clk = ~clk;

    payload_streamer #(
        .CHANNELS(CH), .ITEM_WIDTH(IW), .DEPTH(DEPTH), .RPT_W(RPT_W)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .start_i(start_i), .len_i(len_i), .rpt_i(rpt_i),
        .abort_i(abort_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_last_o(out_last_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mem_m [DEPTH];
    beat_t         q[$];
    logic          m_valid, m_busy, m_done, m_err, m_last, m_fin;
    logic [DW-1:0] m_data;

    // Expand the whole stream (len x passes beats) up front, write-first on the start cycle
    function automatic void fill_queue(input int len, input int passes, input logic we,
                                       input int waddr, input logic [DW-1:0] wdata);
        logic [DW-1:0] d;
        q.delete();
        for (int p = 0; p < passes; p++) begin
            for (int k = 0; k < len; k++) begin
                d = (we && waddr == k) ? wdata : mem_m[k];
                q.push_back({d, (k == len - 1)});
            end
        end
    endfunction

    // Model advances on the clock edge from the inputs and its own beat queue
    always @(posedge clk) begin
        if (!reset_ni) begin
            q.delete();
            m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0;
            m_last <= 1'b0; m_fin <= 1'b0; m_data <= {DW{1'b0}};
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_err <= wr_en_i || start_i;
                if (abort_i) begin
                    q.delete();
                    m_busy <= 1'b0; m_valid <= 1'b0; m_last <= 1'b0;
                end else if (out_ready_i) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        m_busy <= 1'b0; m_valid <= 1'b0; m_last <= 1'b0;
                        m_done <= 1'b1; m_fin <= 1'b1;
                    end else begin
                        m_data <= q[0].data; m_last <= q[0].last;
                    end
                end
            end else begin
                m_fin <= 1'b0;
                if (wr_en_i && int'(wr_addr_i) < DEPTH) mem_m[wr_addr_i] <= wr_data_i;
                if (m_fin) begin
                    m_err <= (wr_en_i && int'(wr_addr_i) >= DEPTH) || start_i;
                end else begin
                    m_err <= (wr_en_i && int'(wr_addr_i) >= DEPTH) ||
                             (start_i && (int'(len_i) == 0 || int'(len_i) > DEPTH));
                    if (start_i && int'(len_i) >= 1 && int'(len_i) <= DEPTH) begin
                        fill_queue(int'(len_i), (rpt_i == 8'd0) ? 1 : int'(rpt_i),
                                   wr_en_i && int'(wr_addr_i) < DEPTH, int'(wr_addr_i), wr_data_i);
                        m_busy <= 1'b1; m_valid <= 1'b1;
                        m_data <= q[0].data; m_last <= q[0].last;
                    end
                end
            end
        end
    end

    // ---------------- compare / monitor ----------------
    logic  chk_en = 1'b0;
    beat_t dut_log[$];
    int    busy_cnt = 0;
    int    done_cnt = 0;
    int    err_cnt  = 0;

    // Compare DUT to model mid-cycle; log accepted beats and count pulses
    always @(negedge clk) begin
        if (chk_en) begin
            chkb("valid", out_valid_o, m_valid);
            chkb("busy", busy_o, m_busy);
            chkb("done", done_o, m_done);
            chkb("err", err_o, m_err);
            chkb("last", out_last_o, m_last);
            if (m_valid) chkd("data", out_data_o, m_data);
        end
        if (reset_ni && out_valid_o === 1'b1 && out_ready_i && !abort_i)
            dut_log.push_back({out_data_o, out_last_o});
        if (busy_o === 1'b1) busy_cnt++;
        if (done_o === 1'b1) done_cnt++;
        if (err_o === 1'b1)  err_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] img(input int k);
        if (k < 4) return {8'(k + 10), 8'(k)};
        else       return {8'(k * 3 + 1), 8'(k)};
    endfunction

    task automatic wait_idle(input int mode, input bit noise);
        int c;
        c = 0;
        while ((m_busy || m_fin) && c < 20000) begin
            tick();
            c++;
            wr_en_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
            if (mode == 1)      out_ready_i = ~out_ready_i;
            else if (mode == 2) out_ready_i = 1'($urandom_range(0, 1));
            else                out_ready_i = 1'b1;
            if (noise) begin
                if ($urandom_range(0, 15) == 0) begin
                    wr_en_i = 1'b1; wr_addr_i = ADDR_W'($urandom); wr_data_i = DW'($urandom);
                end
                if ($urandom_range(0, 15) == 0) begin
                    start_i = 1'b1; len_i = LEN_W'($urandom_range(0, DEPTH + 1));
                end
                if ($urandom_range(0, 63) == 0) abort_i = 1'b1;
            end
        end
        wr_en_i = 1'b0; start_i = 1'b0; abort_i = 1'b0;
        chkb("idle_reached", busy_o | out_valid_o, 1'b0);
    endtask

    task automatic run_stream(input int len, input int rpt, input int mode, input bit noise);
        len_i = LEN_W'(len); rpt_i = RPT_W'(rpt); start_i = 1'b1; out_ready_i = 1'b1;
        if (noise && $urandom_range(0, 3) == 0) begin
            wr_en_i = 1'b1; wr_addr_i = ADDR_W'($urandom_range(0, 3)); wr_data_i = DW'($urandom);
        end
        tick();
        start_i = 1'b0; wr_en_i = 1'b0;
        wait_idle(mode, noise);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int nw;
        int len;
        reset_ni = 1'b0; wr_en_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
        start_i = 1'b0; len_i = '0; rpt_i = '0; abort_i = 1'b0; out_ready_i = 1'b0;
        tick(); tick(); tick();
        chkb("rst_valid", out_valid_o, 1'b0);
        chkd("rst_data", out_data_o, 16'h0000);
        chkb("rst_last", out_last_o, 1'b0);
        chkb("rst_busy", busy_o, 1'b0);
        chkb("rst_done", done_o, 1'b0);
        chkb("rst_err", err_o, 1'b0);
        reset_ni = 1'b1;
        chk_en = 1'b1;

        // Preload full buffer with a known image
        for (int i = 0; i < DEPTH; i++) begin
            wr_en_i = 1'b1; wr_addr_i = ADDR_W'(i); wr_data_i = {8'(i * 3 + 1), 8'(i)};
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            wr_addr_i = ADDR_W'(i); wr_data_i = {8'(i + 10), 8'(i)};
            tick();
        end
        wr_en_i = 1'b0;
        tick();

        // T1: len 4, single pass, ready held high
        dut_log.delete(); busy_cnt = 0; done_cnt = 0;
        run_stream(4, 1, 0, 1'b0);
        chki("t1_count", dut_log.size(), 4);
        for (int k = 0; k < 4 && k < dut_log.size(); k++) begin
            chkd("t1_data", dut_log[k].data, {8'(k + 10), 8'(k)});
            chkb("t1_last", dut_log[k].last, 1'(k == 3));
        end
        chki("t1_busy_cycles", busy_cnt, 4);
        chki("t1_done_pulses", done_cnt, 1);

        // T2: len 4, three passes, ready toggling 1,0,1,0
        dut_log.delete(); busy_cnt = 0; done_cnt = 0;
        run_stream(4, 3, 1, 1'b0);
        chki("t2_count", dut_log.size(), 12);
        for (int k = 0; k < 12 && k < dut_log.size(); k++) begin
            chkd("t2_data", dut_log[k].data, {8'(k % 4 + 10), 8'(k % 4)});
            chkb("t2_last", dut_log[k].last, 1'(k % 4 == 3));
        end
        chki("t2_busy_cycles", busy_cnt, 23);
        chki("t2_done_pulses", done_cnt, 1);

        // T3: illegal lengths
        dut_log.delete(); busy_cnt = 0; err_cnt = 0;
        out_ready_i = 1'b1;
        len_i = LEN_W'(0); start_i = 1'b1; tick(); start_i = 1'b0; tick();
        chki("t3_err_len0", err_cnt, 1);
        len_i = LEN_W'(DEPTH + 1); start_i = 1'b1; tick(); start_i = 1'b0; tick();
        chki("t3_err_lenbig", err_cnt, 2);
        chki("t3_busy", busy_cnt, 0);
        chki("t3_beats", dut_log.size(), 0);

        // T4: write and start while busy are rejected
        dut_log.delete(); err_cnt = 0; done_cnt = 0;
        len_i = LEN_W'(4); rpt_i = 8'd2; start_i = 1'b1; out_ready_i = 1'b1;
        tick(); start_i = 1'b0;
        wr_en_i = 1'b1; wr_addr_i = ADDR_W'(1); wr_data_i = 16'hFFFF;
        tick(); wr_en_i = 1'b0;
        tick();
        start_i = 1'b1; len_i = LEN_W'(2);
        tick(); start_i = 1'b0;
        wait_idle(0, 1'b0);
        chki("t4_err_pulses", err_cnt, 2);
        chki("t4_count", dut_log.size(), 8);
        for (int k = 0; k < 8 && k < dut_log.size(); k++)
            chkd("t4_data", dut_log[k].data, {8'(k % 4 + 10), 8'(k % 4)});
        chki("t4_done_pulses", done_cnt, 1);

        // T5: abort after two transfers, then replay from beat 0
        dut_log.delete(); done_cnt = 0;
        out_ready_i = 1'b1; len_i = LEN_W'(4); rpt_i = 8'd1; start_i = 1'b1;
        tick(); start_i = 1'b0;
        tick(); tick();
        abort_i = 1'b1;
        tick(); abort_i = 1'b0;
        chkb("t5_valid_after_abort", out_valid_o, 1'b0);
        chkb("t5_busy_after_abort", busy_o, 1'b0);
        tick();
        chki("t5_count", dut_log.size(), 2);
        chki("t5_done_pulses", done_cnt, 0);
        run_stream(4, 1, 0, 1'b0);
        chki("t5_replay_count", dut_log.size(), 6);
        if (dut_log.size() > 2) chkd("t5_replay_first", dut_log[2].data, 16'h0A00);

        // T6: reset mid-stream, then full-depth stream
        done_cnt = 0;
        out_ready_i = 1'b1; len_i = LEN_W'(4); rpt_i = 8'd3; start_i = 1'b1;
        tick(); start_i = 1'b0;
        tick(); tick();
        reset_ni = 1'b0;
        tick();
        chkb("t6_valid", out_valid_o, 1'b0);
        chkd("t6_data", out_data_o, 16'h0000);
        chkb("t6_last", out_last_o, 1'b0);
        chkb("t6_busy", busy_o, 1'b0);
        chkb("t6_done", done_o, 1'b0);
        chkb("t6_err", err_o, 1'b0);
        reset_ni = 1'b1;
        tick(); tick();
        chki("t6_no_done", done_cnt, 0);
        dut_log.delete(); busy_cnt = 0;
        run_stream(DEPTH, 1, 0, 1'b0);
        chki("t6_count", dut_log.size(), DEPTH);
        chki("t6_busy_cycles", busy_cnt, DEPTH);
        for (int k = 0; k < DEPTH && k < dut_log.size(); k++)
            chkd("t6_data_k", dut_log[k].data, img(k));
        if (dut_log.size() == DEPTH) chkb("t6_last_final", dut_log[DEPTH - 1].last, 1'b1);

        // Randomized streams with noise, checked by the model every cycle
        for (int it = 0; it < 40; it++) begin
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                wr_en_i = 1'b1; wr_addr_i = ADDR_W'($urandom); wr_data_i = DW'($urandom);
                tick();
            end
            wr_en_i = 1'b0;
            if ($urandom_range(0, 7) == 0) len = $urandom_range(0, DEPTH + 1);
            else                           len = $urandom_range(0, 24);
            run_stream(len, $urandom_range(0, 3), $urandom_range(0, 2), 1'b1);
        end

        tick(); tick();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
